// File: rtl/dram_refresh_scheduler.sv
// DRAM auto-refresh scheduler: interval ticker, owed-refresh counter and a req/ack/busy FSM.
// Optional macro REFRESH_BURST_EN: chain owed refreshes back-to-back without an IDLE gap.
module dram_refresh_scheduler #(
    parameter int INTERVAL  = 390,
    parameter int CNT_W     = 9,
    parameter int MAX_PEND  = 8,
    parameter int PEND_W    = 4,
    parameter int URGENT_TH = 6,
    parameter int TRFC      = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              REFRESH_ACK,
    output logic              REFRESH_REQ,
    output logic              REFRESH_URGENT,
    output logic              BUSY,
    output logic [PEND_W-1:0] PENDING,
    output logic              OVERFLOW,
    output logic [1:0]        dbg_state_o
);

    // Handshake: REFRESH_REQ is a level held until the cycle REFRESH_ACK is sampled high
    // in REQ; that cycle is the accept. ACK seen in any other state is ignored.

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_BUSY = 2'd2} state_e;

    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(INTERVAL - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);
    localparam logic [PEND_W-1:0] URG_LVL    = PEND_W'(URGENT_TH);
    localparam logic [3:0]        TRFC_LOAD  = 4'(TRFC - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              tick;
    logic              ack_accept;

    state_e            state_q;
    logic              req_q;
    logic              busy_q;
    logic [3:0]        trfc_q;

    assign ack_accept = (state_q == S_REQ) && REFRESH_ACK;

    always_comb begin
        cnt_d  = cnt_q;
        tick   = 1'b0;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ENABLE) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_RELOAD;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
        // A tick and an accept in the same cycle cancel; saturate rather than wrap.
        if (tick && !ack_accept) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (ack_accept && !tick && (pend_q != '0)) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= CNT_RELOAD;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            trfc_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_q != '0) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (REFRESH_ACK) begin
                        state_q <= S_BUSY;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        trfc_q  <= TRFC_LOAD;
                    end
                end
                S_BUSY: begin
                    if (trfc_q == '0) begin
                        busy_q <= 1'b0;
`ifdef REFRESH_BURST_EN
                        if (pend_q != '0) begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
`else
                        state_q <= S_IDLE;
`endif
                    end else begin
                        trfc_q <= trfc_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign REFRESH_REQ    = req_q;
    assign BUSY           = busy_q;
    assign PENDING        = pend_q;
    assign OVERFLOW       = ovf_q;
    assign REFRESH_URGENT = (pend_q >= URG_LVL);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Scoreboard bench for dram_refresh_scheduler (INTERVAL=10, TRFC=3, MAX_PEND=8, URGENT_TH=6).
module tb_dram_refresh_scheduler;

    localparam int INTERVAL = 10;
    localparam int TRFC     = 3;
`ifdef REFRESH_BURST_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 5;
`endif

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       ack;
    logic       req;
    logic       urgent;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;
    logic [1:0] dbg_state;

    int unsigned cyc;
    int          n_checks;
    int          n_pass;
    int          c0;
    logic [31:0] exp_q[$];

    dram_refresh_scheduler #(
        .INTERVAL(INTERVAL), .CNT_W(4), .MAX_PEND(8), .PEND_W(4), .URGENT_TH(6), .TRFC(TRFC)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .REFRESH_ACK(ack),
        .REFRESH_REQ(req), .REFRESH_URGENT(urgent), .BUSY(busy),
        .PENDING(pending), .OVERFLOW(overflow), .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every REQ rising edge is popped against the expected cycle queue.
    task automatic monitor();
        logic req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (req && !req_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL req_rise_unexpected: got rise at cycle %0d expected none", cyc);
                end else begin
                    check("req_rise_cycle", int'(cyc), int'(exp_q.pop_front()));
                end
            end
            req_prev = req;
        end
    endtask

    task automatic reset_dut(input logic en);
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        ack    = 1'b0;
        repeat (2) @(negedge clk);
        enable = en;
        rst_n  = 1'b1;
        c0     = int'(cyc);
    endtask

    task automatic wait_cyc(input int target);
        while (int'(cyc) < target) @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!req && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = req;
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_req_timeout: got req=0 expected req=1 within 30 cycles");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, int'(req), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pending"}, int'(pending), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_urgent"}, int'(urgent), 0);
    endtask

    initial begin
        bit ok;
        int blen;
        int first_urg, pend_at_urg, first_ovf, max_pend;
        int e;
        int rem;
        cyc = 0;
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        ack = 1'b0;
        c0 = 0;
        fork
            monitor();
        join_none

        // reset values
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        // 1: first REQ in period 12 (11 edges after release), BUSY for TRFC cycles
        reset_dut(1'b1);
        exp_q.push_back(32'(c0 + 11));
        wait_req(ok);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        blen = 0;
        while (busy && blen < 20) begin
            blen++;
            @(negedge clk);
        end
        check("t1_busy_len", blen, TRFC);
        check("t1_pending", int'(pending), 0);

        // 2: no ACK for 100 cycles -> saturate, urgent, overflow, then drain
        reset_dut(1'b1);
        exp_q.push_back(32'(c0 + 11));
        first_urg = -1; pend_at_urg = -1; first_ovf = -1; max_pend = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (urgent && first_urg < 0) begin
                first_urg = n;
                pend_at_urg = int'(pending);
            end
            if (overflow && first_ovf < 0) first_ovf = n;
            if (int'(pending) > max_pend) max_pend = int'(pending);
        end
        check("t2_urgent_first", first_urg, 60);
        check("t2_pending_at_urgent", pend_at_urg, 6);
        check("t2_overflow_first", first_ovf, 90);
        check("t2_pending_max", max_pend, 8);
        check("t2_pending_end", int'(pending), 8);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_req(ok);
            if (!ok) break;
            ack = 1'b1;
            if (i < 7) exp_q.push_back(32'(int'(cyc) + GAP));
            @(negedge clk);
            ack = 1'b0;
        end
        repeat (6) @(negedge clk);
        check("t2_drained_pending", int'(pending), 0);
        check("t2_overflow_sticky", int'(overflow), 1);
        check("t2_urgent_cleared", int'(urgent), 0);

        // 3: tick and accept in the same cycle with PENDING=3
        reset_dut(1'b1);
        exp_q.push_back(32'(c0 + 11));
        wait_cyc(c0 + 30);
        check("t3_pending_before", int'(pending), 3);
        wait_cyc(c0 + 39);
        ack = 1'b1;
        exp_q.push_back(32'(int'(cyc) + GAP));
        @(negedge clk);
        ack = 1'b0;
        check("t3_pending_same", int'(pending), 3);
        check("t3_busy", int'(busy), 1);
        wait_cyc(c0 + 39 + GAP + 2);

        // 4: ENABLE low freezes the interval counter
        reset_dut(1'b1);
        wait_cyc(c0 + 4);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        check("t4_pending_frozen", int'(pending), 0);
        check("t4_req_frozen", int'(req), 0);
        e = int'(cyc);
        rem = INTERVAL - 1 - 4;
        enable = 1'b1;
        exp_q.push_back(32'(e + rem + 2));
        wait_cyc(e + rem);
        check("t4_pending_before_tick", int'(pending), 0);
        wait_cyc(e + rem + 1);
        check("t4_pending_after_tick", int'(pending), 1);
        wait_cyc(e + rem + 3);

        // 5: asynchronous reset in the middle of BUSY
        reset_dut(1'b1);
        exp_q.push_back(32'(c0 + 11));
        wait_cyc(c0 + 20);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t5_busy_before", int'(busy), 1);
        check("t5_pending_before", int'(pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");

        // 6: PENDING=3 with ACK held high -> REQ spacing GAP
        reset_dut(1'b1);
        exp_q.push_back(32'(c0 + 11));
        wait_cyc(c0 + 30);
        enable = 1'b0;
        ack = 1'b1;
        exp_q.push_back(32'(c0 + 30 + GAP));
        exp_q.push_back(32'(c0 + 30 + 2 * GAP));
        wait_cyc(c0 + 30 + 3 * GAP + 2);
        check("t6_pending_end", int'(pending), 0);
        check("t6_req_end", int'(req), 0);
        ack = 1'b0;

        check("scoreboard_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
